// File: rtl/register_file_pkg.sv
// Shared constants and the byte-lane merge used by the register storage and
// by the bypass path. The merge must be identical in both places.
package register_file_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;

    // Applied once per byte lane, so it works for any XLEN that is a multiple of 8.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_val,
        input logic [7:0] new_val,
        input logic       strb
    );
        return strb ? new_val : old_val;
    endfunction

endpackage

// File: rtl/register_file_nbit_register.sv
// One storage entry: a WIDTH-bit register with per-byte load enables and an
// asynchronous active-low clear.
module nbit_register
    import register_file_pkg::*;
#(
    parameter int WIDTH = XLEN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH/8-1:0] load,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q
);

    logic [WIDTH-1:0] next;

    for (genvar b = 0; b < WIDTH/8; b++) begin : g_lane
        assign next[b*8 +: 8] = merge_byte(q[b*8 +: 8], d[b*8 +: 8], load[b]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= next;
        end
    end

endmodule

// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one byte-strobed
// write port, x0 reads as zero, optional same-cycle write-to-read bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = NREGS_DEFAULT,
    parameter  bit BYPASS = 1'b0,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rs1_addr,
    output logic [XLEN-1:0]   rs1_data,
    input  logic [AW-1:0]     rs2_addr,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN/8-1:0] wr_strb,
    input  logic [XLEN-1:0]   wr_data
);

    localparam int NSLOTS = 2 ** AW;

    // Sized to the full address space; slots 0 and >= NREGS are tied to zero,
    // so out-of-range reads need no separate range check.
    logic [XLEN-1:0] regs [NSLOTS];

    for (genvar i = 0; i < NSLOTS; i++) begin : g_reg
        if (i == REG_ZERO || i >= NREGS) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            logic [XLEN/8-1:0] load;
            assign load = (wr_en && wr_addr == AW'(i)) ? wr_strb : '0;

            nbit_register #(.WIDTH(XLEN)) u_reg (
                .clk  (clk),
                .rst  (rst),
                .load (load),
                .d    (wr_data),
                .q    (regs[i])
            );
        end
    end

    logic            wr_live;
    logic [XLEN-1:0] wr_old;
    logic [XLEN-1:0] wr_merged;

    // Gated by rst so the bypass cannot leak data while the array is held clear.
    assign wr_live = BYPASS && rst && wr_en && (|wr_strb)
                     && ({1'b0, wr_addr} != (AW+1)'(REG_ZERO))
                     && ({1'b0, wr_addr} <  (AW+1)'(NREGS));
    assign wr_old  = regs[wr_addr];

    for (genvar b = 0; b < XLEN/8; b++) begin : g_merge
        assign wr_merged[b*8 +: 8] = merge_byte(wr_old[b*8 +: 8], wr_data[b*8 +: 8], wr_strb[b]);
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (wr_live && rs1_addr == wr_addr) rs1_data = wr_merged;
        if (wr_live && rs2_addr == wr_addr) rs2_data = wr_merged;
    end

endmodule

// File: doc/register_file.md
# register_file

Parametrised general-purpose register file for the single-cycle core: NREGS registers of XLEN bits, two combinational read ports, one clocked write port with byte strobes, register 0 hardwired to zero. Generalises the one-bit load-enable register (DataIn/Select/Q) to a multi-bit, multi-entry array with an optional write-to-read bypass. Sits between instruction decode (source/destination addresses) and the ALU/writeback mux.

## Interface
- XLEN, 32, register width in bits; multiple of 8
- NREGS, 32, number of registers; 2..64
- AW, $clog2(NREGS), address width (derived, not overridden)
- BYPASS, 0, 1 = a read of the register being written this cycle returns the merged write data
- clk  in  1  clock; all writes on rising edge
- rst  in  1  reset, asynchronous, active-low; clears every register to 0
- rs1_addr  in  AW  read port 1 address
- rs1_data  out  XLEN  read port 1 data
- rs2_addr  in  AW  read port 2 address
- rs2_data  out  XLEN  read port 2 data
- wr_en  in  1  write enable (the per-register "Select")
- wr_addr  in  AW  write address
- wr_strb  in  XLEN/8  byte-lane write strobes; bit i enables bits [8i+7:8i]
- wr_data  in  XLEN  write data

## Operation
- Storage: registers 1..NREGS-1, each XLEN bits. Register 0 not stored; reads of it always return 0.
- Write: on rising clk with rst high, if wr_en=1, wr_addr in 1..NREGS-1 and wr_strb!=0, the enabled byte lanes of reg[wr_addr] load wr_data; disabled lanes hold.
- Ignored writes (no state change): wr_en=0; wr_addr=0; wr_addr>=NREGS (NREGS not a power of 2); wr_strb all zero.
- Read: rs*_data = reg[rs*_addr], combinational; 0 if addr=0 or addr>=NREGS.
- Bypass (BYPASS=1): if wr_en=1 and rs*_addr==wr_addr and the write is not ignored, rs*_data = merged value (strobed lanes from wr_data, remaining lanes from reg[wr_addr]). BYPASS=0: reads show the old value until the edge.
- Both read ports independent; same address on both returns identical data.

## Timing
- Reset: asserting rst low clears all registers immediately, independent of clk; rs1_data/rs2_data = 0 while rst low (after combinational settle). A write coinciding with the edge while rst is low is discarded.
- Reset release: first write takes effect on the first rising edge with rst high.
- Write latency: data visible on read ports in the cycle after the write edge (BYPASS=0); same cycle, combinationally (BYPASS=1).
- Read latency: zero cycles; no read enable, no handshake.
- Back-to-back writes to the same register on consecutive edges: each applies in order; last strobed value wins per byte.

## Structure
- Shared package: default XLEN, NREGS; constant REG_ZERO = 0; function for byte-strobe merge (old, new, strb) used by storage and bypass.
- Sub-module: nbit_register (WIDTH, async active-low rst, per-byte load enables, Q); register_file instantiates NREGS-1 of them via generate, driving each enable from wr_en & address decode & wr_strb.
- Read muxes and bypass logic live in register_file top.

## Test plan
- Reset: write 0xDEADBEEF to x5, drop rst low mid-cycle -> rs1_data(x5)=0 immediately, before next edge; stays 0 after release until rewritten.
- Basic write/read: write 0x12345678 to x1, strb=4'b1111 -> next cycle rs1(x1)=0x12345678, rs2(x1)=0x12345678.
- x0: write 0xFFFFFFFF to x0 -> rs1(x0)=0; all other registers unchanged.
- Byte strobes: x2=0x11223344, then write 0xAABBCCDD strb=4'b0101 -> x2=0x11BB33DD.
- Hold/enable: wr_en=0 with wr_addr=x2, data 0 -> x2 unchanged; wr_strb=0 with wr_en=1 -> unchanged.
- Bypass: BYPASS=1, x3=0, write 0xCAFEF00D to x3 with rs1_addr=x3 -> rs1_data=0xCAFEF00D before the edge; BYPASS=0 same stimulus -> 0 before edge, 0xCAFEF00D after.
